// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request/serial-output bundle between a pattern source and seq_pattern_tx
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, reps, gap, abort,
        input  ready, x, x_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, reps, gap, abort,
        output ready, x, x_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first bit-serial pattern transmitter with repeat count and idle gaps
module seq_pattern_tx #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   REP_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input logic              clk,
    input logic              rst,
    seq_pattern_tx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

    localparam logic [LEN_W-1:0] WL = LEN_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d, sh;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, len_in;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic             x_q, x_d, xv_q, xv_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;

    assign len_in = (bus.len == '0 || bus.len > WL) ? WL : bus.len;
    // Outputs are precomputed from next state so every port comes straight from a flop
    assign sh = pat_d >> idx_d;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                pat_d   = bus.pattern;
                len_d   = len_in;
                rep_d   = bus.reps;
                gap_d   = bus.gap;
                idx_d   = len_in - LEN_W'(1);
                state_d = SHIFT;
            end
            SHIFT: if (bus.abort) state_d = IDLE;
            else if (idx_q != '0) idx_d = idx_q - LEN_W'(1);
            else if (rep_q != '0) begin
                rep_d   = rep_q - REP_W'(1);
                idx_d   = len_q - LEN_W'(1);
                gcnt_d  = gap_q - GAP_W'(1);
                state_d = (gap_q != '0) ? GAP : SHIFT;
            end else state_d = DONE;
            GAP: if (bus.abort) state_d = IDLE;
            else if (gcnt_q == '0) state_d = SHIFT;
            else gcnt_d = gcnt_q - GAP_W'(1);
            default: state_d = IDLE;
        endcase
        x_d     = (state_d == SHIFT) ? sh[0] : IDLE_LVL;
        xv_d    = state_d == SHIFT;
        busy_d  = state_d == SHIFT || state_d == GAP;
        done_d  = state_d == DONE;
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            x_q     <= IDLE_LVL;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = xv_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed cycle-by-cycle checks of seq_pattern_tx output codes
module tb_seq_pattern_tx;
    // Output code {x, x_valid, busy, done, ready}
    localparam logic [4:0] B1 = 5'b11100, B0 = 5'b01100, G = 5'b00100, D = 5'b00010, I = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   fires = 0;
    logic [2:0] hist = '0;
    logic [4:0] seq[$];

    seq_pattern_tx_if #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) bus ();

    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_W(4), .IDLE_LVL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic [4:0] e);
        logic [4:0] obs;
        @(negedge clk);
        obs = {bus.x, bus.x_valid, bus.busy, bus.done, bus.ready};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, e);
        end
        if (bus.x_valid === 1'b1) begin
            hist = {hist[1:0], bus.x};
            if (hist == 3'b110) fires++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic run(input string tag, input logic [4:0] s[$]);
        foreach (s[i]) step(tag, s[i]);
    endtask

    task automatic accept(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
        bus.start = 1'b1;
        bus.pattern = p;
        bus.len = l;
        bus.reps = r;
        bus.gap = g;
        hist = '0;
        fires = 0;
    endtask

    task automatic chk_fires(input string tag, input int n);
        checks++;
        assert (fires == n) else begin
            errors++;
            $error("FAIL %s fires obs=%0d exp=%0d", tag, fires, n);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pattern = '0;
        bus.len = '0;
        bus.reps = '0;
        bus.gap = '0;
        repeat (2) @(posedge clk);
        step("reset", I);
        rst = 1'b0;
        step("idle", I);

        accept(8'h06, 4'd3, 4'd0, 4'd0);
        seq = '{B1, B1, B0, D, I};
        run("single", seq);
        chk_fires("single", 1);

        accept(8'h06, 4'd3, 4'd2, 4'd2);
        seq = '{B1, B1, B0, G, G, B1, B1, B0, G, G, B1, B1, B0, D, I};
        run("gap2", seq);
        chk_fires("gap2", 3);

        accept(8'h06, 4'd3, 4'd1, 4'd0);
        seq = '{B1, B1, B0, B1, B1, B0, D, I};
        run("b2b", seq);
        chk_fires("b2b", 2);

        accept(8'hA5, 4'd0, 4'd0, 4'd0);
        seq = '{B1, B0, B1, B0, B0, B1, B0, B1, D, I};
        run("len0", seq);

        accept(8'hA5, 4'd12, 4'd0, 4'd0);
        seq = '{B1, B0, B1, B0, B0, B1, B0, B1, D, I};
        run("len12", seq);

        accept(8'h06, 4'd3, 4'd0, 4'd0);
        step("busy_start", B1);
        bus.start = 1'b1;
        bus.pattern = 8'hFF;
        bus.len = 4'd1;
        step("busy_start", B1);
        bus.abort = 1'b1;
        step("abort", I);
        step("abort_idle", I);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step("abort_start", I);
        step("abort_start", I);

        accept(8'h06, 4'd3, 4'd1, 4'd3);
        seq = '{B1, B1, B0, G};
        run("rst_gap", seq);
        rst = 1'b1;
        step("rst_gap", I);
        rst = 1'b0;
        step("rst_gap", I);

        accept(8'h01, 4'd1, 4'd15, 4'd0);
        seq = {};
        repeat (16) seq.push_back(B1);
        seq.push_back(D);
        seq.push_back(I);
        run("reps15", seq);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Bit-serial pattern transmitter. It is the generator side of the team's serial sequence-detector blocks.
- Accepts a parallel pattern through a start/ready handshake and shifts it out MSB-first, one bit per clock.
- Supports a programmable repeat count and programmable idle gap cycles between copies.
- Drives the single-bit serial input of downstream detectors in the design and in test benches.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of len port; must satisfy 2^LEN_W > WIDTH.
- REP_W, 4, width of reps port.
- GAP_W, 4, width of gap port.
- IDLE_LVL, 1'b0, level driven on x when no pattern bit is being sent.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request to send; sampled only when ready=1.
- pattern  in  WIDTH  bits to send; active field is pattern[len-1:0].
- len  in  LEN_W  number of bits per copy.
- reps  in  REP_W  extra copies; total copies = reps+1.
- gap  in  GAP_W  idle cycles inserted between consecutive copies.
- abort  in  1  synchronous cancel of the current transfer.
- ready  out  1  high only in IDLE.
- x  out  1  serial data.
- x_valid  out  1  high while x carries a pattern bit.
- busy  out  1  high in SHIFT and GAP.
- done  out  1  one-cycle pulse after the last bit of the last copy.

Behaviour:
- Moore outputs, all registered. States: IDLE, SHIFT, GAP, DONE.
- Reset values: state=IDLE, ready=1, x=IDLE_LVL, x_valid=0, busy=0, done=0, all counters 0.
- Reset has priority over every other input.
- IDLE:
  - ready=1; x=IDLE_LVL.
  - On start=1 at edge k: latch pattern, len, reps and gap into internal registers, then enter SHIFT.
  - Input ports are don't-care after the accept edge.
- Length rule: len=0 or len>WIDTH is clamped to WIDTH. Legal range 1..WIDTH.
- Latency: first bit, pattern[len-1], is valid on x during the cycle after edge k.
- SHIFT:
  - Each cycle drives the next lower bit; x_valid=1, busy=1.
  - Bit index counts len-1 down to 0.
  - After bit 0:
    - copies remaining and gap>0 -> GAP.
    - copies remaining and gap=0 -> next copy starts immediately at pattern[len-1] (back-to-back, no bubble).
    - no copies remaining -> DONE.
- GAP: exactly gap cycles with x=IDLE_LVL, x_valid=0, busy=1; then SHIFT at pattern[len-1].
- DONE: exactly one cycle with done=1, ready=0, busy=0, x=IDLE_LVL; then IDLE.
- Earliest restart: start may be accepted on the first IDLE cycle, i.e. one cycle after DONE.
- Repeat counter: holds remaining extra copies and decrements at the end of each copy. reps=2^REP_W-1 sends 2^REP_W copies with no wrap.
- start while ready=0 is ignored; no queuing.
- abort=1 in SHIFT, GAP or DONE -> IDLE on the next edge with no done pulse; x returns to IDLE_LVL.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and start is not accepted.
- Total cycles, accept to done: (reps+1)*len + reps*gap, with done in the following cycle.

Test Plan:
- pattern=8'b0000_0110, len=3, reps=0, gap=0, start 1 cycle -> x=1,1,0 with x_valid=1 for 3 cycles, then done=1 for 1 cycle, then ready=1. A bench 110 detector model fires once.
- Same pattern, reps=2, gap=2 -> x sequence 1,1,0,I,I,1,1,0,I,I,1,1,0 (I=IDLE_LVL, x_valid=0 on I), 13 cycles, then done. Detector fires 3 times.
- Same pattern, reps=1, gap=0 -> x=1,1,0,1,1,0 back-to-back, x_valid continuous for 6 cycles, single done pulse.
- pattern=8'hA5, len=0 -> clamped to 8; x=1,0,1,0,0,1,0,1, then done.
- start during SHIFT -> ignored, outputs unchanged. abort on the 2nd bit of a 3-bit copy -> next cycle IDLE, ready=1, no done. rst asserted mid-GAP -> all outputs at reset values the next cycle.
- reps=15, len=1, pattern bit 1, gap=0 -> x=1 for 16 consecutive cycles, then done; counter does not wrap.
